// File: rtl/unsigned_mul_arbiter_8x8_pkg.sv
// Shared widths and the stage-1 operand record for the arbitrated 8x8 multiplier.
package unsigned_mul_arbiter_8x8_pkg;

  localparam int OP_W             = 8;
  localparam int PROD_W           = 16;
  localparam int APPROX_DROP_BITS = 2;

  typedef struct packed {
    logic [OP_W-1:0] x;
    logic [OP_W-1:0] y;
    logic            approx;
  } operand_t;

endpackage

// File: rtl/unsigned_mul_arbiter_8x8_core.sv
// Combinational 8x8 multiplier: exact product, or one that drops the x[1:0] rows
// except for the cross terms landing on bit 8. Zero latency, no flow control.
module mul8_approx_l2_core
  import unsigned_mul_arbiter_8x8_pkg::*;
(
  input  logic [OP_W-1:0]   x,
  input  logic [OP_W-1:0]   y,
  input  logic              approx,
  output logic [PROD_W-1:0] z
);

  localparam int HI_W = 2*OP_W - APPROX_DROP_BITS;

  logic [HI_W-1:0]   pp_hi;
  logic [PROD_W-1:0] exact_z;
  logic [PROD_W-1:0] approx_z;
  logic              carry_or;
  logic              carry_top;

  assign exact_z   = PROD_W'(x) * PROD_W'(y);
  assign pp_hi     = HI_W'(y) * HI_W'(x[OP_W-1:APPROX_DROP_BITS]);
  // Only the partial products of the dropped rows that reach bit 8 are kept.
  assign carry_or  = (x[0] & y[7]) | (x[1] & y[6]);
  assign carry_top = x[1] & y[7];
  assign approx_z  = {pp_hi, {APPROX_DROP_BITS{1'b0}}}
                   + (PROD_W'(carry_or) << OP_W)
                   + (PROD_W'(carry_top) << OP_W);
  assign z         = approx ? approx_z : exact_z;

endmodule

// File: rtl/unsigned_mul_arbiter_8x8.sv
// Round-robin arbitrated 2-stage multiplier; transfer-to-out_valid latency 2 cycles.
// out_ready low freezes stage 2 and a full stage 1, and withdraws req_ready.
module unsigned_mul_arbiter_8x8
  import unsigned_mul_arbiter_8x8_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*OP_W-1:0] req_x,
  input  logic [NREQ*OP_W-1:0] req_y,
  input  logic [NREQ-1:0]      req_approx,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PROD_W-1:0]    out_z,
  output logic [ID_W-1:0]      out_id
);

  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   grant_id;
  logic              grant_vld;
  logic              s1_vld;
  operand_t          s1_op;
  logic [ID_W-1:0]   s1_id;
  logic              s2_take;
  logic              s1_take;
  logic              xfer;
  logic [PROD_W-1:0] core_z;

  assign s2_take = !out_valid || out_ready;
  assign s1_take = !s1_vld || s2_take;

  // Search starts one past the last winner, wrapping at NREQ.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (int'(last_grant) + k) % NREQ;
      if (!grant_vld && req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_id  = ID_W'(idx);
      end
    end
  end

  assign req_ready = (grant_vld && s1_take && !rst) ? (NREQ'(1) << grant_id) : '0;
  assign xfer      = |req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= ID_W'(NREQ-1);
      s1_vld     <= 1'b0;
      s1_op      <= '0;
      s1_id      <= '0;
      out_valid  <= 1'b0;
      out_z      <= '0;
      out_id     <= '0;
    end else begin
      if (xfer) begin
        last_grant <= grant_id;
      end
      if (s1_take) begin
        s1_vld <= xfer;
        if (xfer) begin
          s1_op.x      <= req_x[OP_W*grant_id +: OP_W];
          s1_op.y      <= req_y[OP_W*grant_id +: OP_W];
          s1_op.approx <= req_approx[grant_id];
          s1_id        <= grant_id;
        end
      end
      if (s2_take) begin
        out_valid <= s1_vld;
        if (s1_vld) begin
          out_z  <= core_z;
          out_id <= s1_id;
        end
      end
    end
  end

  mul8_approx_l2_core u_core (
    .x      (s1_op.x),
    .y      (s1_op.y),
    .approx (s1_op.approx),
    .z      (core_z)
  );

endmodule

// File: tb/tb_unsigned_mul_arbiter_8x8.sv
// Directed and randomized checks of arbitration, latency, stall, reset and product values.
module tb_unsigned_mul_arbiter_8x8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [31:0] req_x = '0;
  logic [31:0] req_y = '0;
  logic [3:0]  req_approx = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_z;
  logic [1:0]  out_id;

  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;
  logic [17:0] exp_q[$];

  unsigned_mul_arbiter_8x8 #(.NREQ(4), .ID_W(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_approx(req_approx),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_id(out_id)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Bit-level partial-product reference for both modes.
  function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y, input logic a);
    int acc;
    acc = 0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (x[i] && y[j] && (!a || i >= 2)) acc += (1 << (i + j));
    if (a) begin
      acc += int'((x[0] & y[7]) | (x[1] & y[6])) << 8;
      acc += int'(x[1] & y[7]) << 8;
    end
    return acc[15:0];
  endfunction

  task automatic set_req(input int i, input logic [7:0] x, input logic [7:0] y, input logic a);
    req_x[8*i +: 8] = x;
    req_y[8*i +: 8] = y;
    req_approx[i]   = a;
    req_valid[i]    = 1'b1;
  endtask

  // One clock: check handshakes seen this cycle, then advance past the edge.
  task automatic step();
    logic [3:0]  acc;
    logic [17:0] e;
    #1;
    chk("ready_onehot0", 32'($onehot0(req_ready)), 1);
    if (out_valid && out_ready) begin
      chk("out_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_id_order", 32'(out_id), 32'(e[17:16]));
        chk("out_z_value", 32'(out_z), 32'(e[15:0]));
      end
    end
    acc = req_valid & req_ready;
    for (int i = 0; i < 4; i++)
      if (acc[i]) begin
        exp_q.push_back({2'(i), model(req_x[8*i +: 8], req_y[8*i +: 8], req_approx[i])});
        n_acc++;
      end
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acc;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  logic [3:0] exp_rdy [5] = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000};

  initial begin
    // Reset state, with every requester asking.
    req_valid = 4'hF;
    #2;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_z", 32'(out_z), 0);
    chk("rst_out_id", 32'(out_id), 0);
    do_reset();

    // Single exact request, full-scale operands.
    out_ready = 1'b1;
    set_req(0, 8'd255, 8'd255, 1'b0);
    #1 chk("single_ready", 32'(req_ready), 1);
    step();
    chk("single_lat1_valid", 32'(out_valid), 0);
    step();
    chk("single_valid", 32'(out_valid), 1);
    chk("single_z", 32'(out_z), 65025);
    chk("single_id", 32'(out_id), 0);
    step();

    // Approximate vs exact on the same operands: bit 8 receives both kept cross terms.
    set_req(1, 8'd3, 8'd192, 1'b1);
    set_req(2, 8'd3, 8'd192, 1'b0);
    set_req(3, 8'd255, 8'd255, 1'b1);
    step();
    step();
    chk("approx_z", 32'(out_z), 512);
    chk("approx_id", 32'(out_id), 1);
    step();
    chk("exact_z", 32'(out_z), 576);
    chk("exact_id", 32'(out_id), 2);
    step();
    chk("approx_full_z", 32'(out_z), 64772);
    chk("approx_full_id", 32'(out_id), 3);
    step();
    step();

    // Round robin with every requester valid continuously.
    do_reset();
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < 4; i++) set_req(i, 8'(10 + i), 8'(20 + k), 1'b0);
      #1 chk("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
      step();
      if (k >= 1) begin
        chk("rr_throughput", 32'(out_valid), 1);
        chk("rr_id", 32'(out_id), 32'((k - 1) % 4));
      end
    end
    req_valid = '0;
    for (int k = 0; k < 3; k++) step();
    chk("rr_drained", 32'(exp_q.size()), 0);

    // Backpressure: three pending, downstream stalled for five cycles.
    do_reset();
    out_ready = 1'b0;
    set_req(0, 8'd17, 8'd3, 1'b0);
    set_req(1, 8'd200, 8'd2, 1'b0);
    set_req(2, 8'd9, 8'd9, 1'b0);
    for (int k = 0; k < 5; k++) begin
      #1 chk("bp_ready", 32'(req_ready), 32'(exp_rdy[k]));
      if (k >= 2) begin
        chk("bp_hold_valid", 32'(out_valid), 1);
        chk("bp_hold_z", 32'(out_z), 51);
        chk("bp_hold_id", 32'(out_id), 0);
      end
      step();
    end
    chk("bp_pending", 32'(req_valid), 32'(4'b0100));
    out_ready = 1'b1;
    for (int k = 0; k < 12 && (exp_q.size() != 0 || req_valid != 0); k++) step();
    chk("bp_all_out", 32'(exp_q.size() + int'(req_valid != 0)), 0);

    // Reset with two results in flight.
    out_ready = 1'b0;
    set_req(3, 8'd7, 8'd7, 1'b0);
    set_req(1, 8'd5, 8'd5, 1'b0);
    step();
    step();
    chk("mid_inflight", 32'(out_valid), 1);
    #2 rst = 1'b1;
    req_valid = 4'b0101;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_z", 32'(out_z), 0);
    chk("mid_rst_ready", 32'(req_ready), 0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    set_req(0, 8'd11, 8'd13, 1'b0);
    set_req(2, 8'd2, 8'd2, 1'b0);
    #1 chk("mid_first_winner", 32'(req_ready), 1);
    step();
    chk("mid_no_stale", 32'(out_valid), 0);
    step();
    chk("mid_new_valid", 32'(out_valid), 1);
    chk("mid_new_z", 32'(out_z), 143);
    chk("mid_new_id", 32'(out_id), 0);
    for (int k = 0; k < 4; k++) step();
    chk("mid_drained", 32'(exp_q.size()), 0);

    // Random traffic with random downstream stalls.
    n_acc = 0;
    for (int c = 0; c < 40000 && n_acc < 10000; c++) begin
      for (int i = 0; i < 4; i++)
        if (!req_valid[i] && $urandom_range(0, 1) == 1)
          set_req(i, 8'($urandom), 8'($urandom), 1'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    chk("rand_count_reached", 32'(n_acc >= 10000), 1);
    req_valid = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) step();
    chk("rand_drained", 32'(exp_q.size()), 0);
    step();
    chk("rand_idle", 32'(out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
